// File: rtl/cpu_state_dumper_pkg.sv
// Shared definitions for the CPU state dumper: FSM encoding, header default
// and frame-length helper used by the RTL and the host-side parser.
package cpu_state_dumper_pkg;

    localparam int unsigned RF_AW        = 5;
    localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_RF      = 3'd2,
        ST_DM_REQ  = 3'd3,
        ST_DM_CAP  = 3'd4,
        ST_DM_SEND = 3'd5,
        ST_CSUM    = 3'd6,
        ST_FIN     = 3'd7
    } dump_state_e;

    // Header + 4 bytes per GPR + one byte per DM location + checksum.
    function automatic int unsigned dump_frame_len(input int unsigned gpr_size,
                                                   input int unsigned dm_size);
        return 2 + 4 * gpr_size + dm_size;
    endfunction

endpackage

// File: rtl/dump_byte_sel.sv
// Little-endian byte lane select from a 32-bit word.
module dump_byte_sel (
    input  logic [31:0] word,
    input  logic [1:0]  sel,
    output logic [7:0]  byte_c
);

    always_comb begin
        byte_c = word[7:0];
        case (sel)
            2'd0: byte_c = word[7:0];
            2'd1: byte_c = word[15:8];
            2'd2: byte_c = word[23:16];
            2'd3: byte_c = word[31:24];
            default: byte_c = word[7:0];
        endcase
    end

endmodule

// File: rtl/cpu_state_dumper.sv
// Streams the GPR file and data memory as one framed, checksummed byte
// stream over a valid/ready interface.
module cpu_state_dumper
    import cpu_state_dumper_pkg::*;
#(
    parameter int unsigned GPR_SIZE      = 32,
    parameter int unsigned DATA_MEM_SIZE = 1024,
    parameter int unsigned DM_AW         = 10,
    parameter logic [7:0]  HDR_BYTE      = HDR_BYTE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [RF_AW-1:0] rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic [DM_AW-1:0] dm_raddr,
    input  logic [7:0]       dm_rdata,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam logic [RF_AW-1:0] RF_LAST = RF_AW'(GPR_SIZE - 1);
    localparam logic [DM_AW-1:0] DM_LAST = DM_AW'(DATA_MEM_SIZE - 1);

    dump_state_e      state_q, state_d;
    logic [RF_AW-1:0] rf_idx_q, rf_idx_d;
    logic [1:0]       byte_sel_q, byte_sel_d;
    logic [7:0]       csum_q, csum_d;
    logic             busy_d, done_d, tx_valid_d;
    logic [7:0]       tx_data_d;
    logic [RF_AW-1:0] rf_raddr_d;
    logic [DM_AW-1:0] dm_raddr_d;

    logic             xfer_c;
    logic [1:0]       sel_c;
    logic [7:0]       byte_c;

    assign xfer_c = tx_valid & tx_ready;
    // Lane of the byte that follows the one currently presented.
    assign sel_c  = (state_q == ST_RF) ? 2'(byte_sel_q + 2'd1) : 2'd0;

    dump_byte_sel u_byte_sel (
        .word   (rf_rdata),
        .sel    (sel_c),
        .byte_c (byte_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rf_idx_q   <= '0;
            byte_sel_q <= '0;
            csum_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            rf_raddr   <= '0;
            dm_raddr   <= '0;
        end else begin
            state_q    <= state_d;
            rf_idx_q   <= rf_idx_d;
            byte_sel_q <= byte_sel_d;
            csum_q     <= csum_d;
            busy       <= busy_d;
            done       <= done_d;
            tx_valid   <= tx_valid_d;
            tx_data    <= tx_data_d;
            rf_raddr   <= rf_raddr_d;
            dm_raddr   <= dm_raddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rf_idx_d   = rf_idx_q;
        byte_sel_d = byte_sel_q;
        csum_d     = csum_q;
        busy_d     = busy;
        done_d     = 1'b0;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        rf_raddr_d = rf_raddr;
        dm_raddr_d = dm_raddr;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_HDR;
                    busy_d     = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HDR_BYTE;
                    csum_d     = '0;
                    rf_idx_d   = '0;
                    byte_sel_d = '0;
                    rf_raddr_d = '0;
                    dm_raddr_d = '0;
                end
            end
            ST_HDR: begin
                if (xfer_c) begin
                    state_d    = ST_RF;
                    tx_data_d  = byte_c;
                    byte_sel_d = '0;
                end
            end
            ST_RF: begin
                if (xfer_c) begin
                    csum_d = 8'(csum_q + tx_data);
                    if (byte_sel_q == 2'd3) begin
                        if (rf_idx_q == RF_LAST) begin
                            state_d    = ST_DM_REQ;
                            tx_valid_d = 1'b0;
                            dm_raddr_d = '0;
                        end else begin
                            rf_idx_d   = RF_AW'(rf_idx_q + 1'b1);
                            byte_sel_d = '0;
                            tx_data_d  = byte_c;
                        end
                    end else begin
                        byte_sel_d = 2'(byte_sel_q + 2'd1);
                        tx_data_d  = byte_c;
                        // Prefetch the next word while its predecessor's top byte is on the bus.
                        if (byte_sel_q == 2'd2 && rf_idx_q != RF_LAST) begin
                            rf_raddr_d = RF_AW'(rf_idx_q + 1'b1);
                        end
                    end
                end
            end
            ST_DM_REQ: begin
                state_d = ST_DM_CAP;
            end
            ST_DM_CAP: begin
                state_d    = ST_DM_SEND;
                tx_data_d  = dm_rdata;
                tx_valid_d = 1'b1;
            end
            ST_DM_SEND: begin
                if (xfer_c) begin
                    csum_d = 8'(csum_q + tx_data);
                    if (dm_raddr == DM_LAST) begin
                        state_d   = ST_CSUM;
                        tx_data_d = 8'(csum_q + tx_data);
                    end else begin
                        state_d    = ST_DM_REQ;
                        tx_valid_d = 1'b0;
                        dm_raddr_d = DM_AW'(dm_raddr + 1'b1);
                    end
                end
            end
            ST_CSUM: begin
                if (xfer_c) begin
                    state_d    = ST_FIN;
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
